wire_ops_tester: RTL and testbench

WIRE_OPS_TESTER -- requirements
Module: wire_ops_tester

---
 rtl/wire_ops_pkg.sv | 24 ++
 rtl/wire_ops_lfsr16.sv | 39 +++
 rtl/wire_ops_tester.sv | 168 ++++++++++++++++
 tb/tb_wire_ops_tester.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/wire_ops_pkg.sv
// Shared types, LFSR constants and the WireOps reference result for the wire_ops tester.
// The polynomial mask is x^16+x^14+x^13+x^11+1 for a right-shifting Galois LFSR.
package wire_ops_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [15:0] LFSR_MASK         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_MASK : 16'h0000);
    endfunction

    function automatic logic [7:0] wire_ops_ref(input logic [7:0] a, input logic [7:0] b,
                                                input logic sel);
        return sel ? (a & b) : (a ^ b);
    endfunction

endpackage

// File: rtl/wire_ops_lfsr16.sv
// 16-bit Galois LFSR: load has priority over advance; state updates one cycle after request.
// No backpressure; the caller decides when to advance.
module wire_ops_lfsr16
    import wire_ops_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        load,
    input  logic        advance,
    output logic [15:0] state_o
);

    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? LFSR_DEFAULT_SEED : SEED;

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = SEED_EFF;
        end else if (advance) begin
            lfsr_d = lfsr_step(lfsr_q);
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            lfsr_q <= SEED_EFF;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state_o = lfsr_q;

endmodule

// File: rtl/wire_ops_tester.sv
// Drives LFSR vectors into a registered WireOps DUT and checks y_i LAT cycles later.
// One vector per RUN cycle, no stalls; start is ignored while busy.
module wire_ops_tester
    import wire_ops_pkg::*;
#(
    parameter int          WIDTH = 8,
    parameter int          LAT   = 1,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             start,
    input  logic [15:0]      num_vec,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic             sel_o,
    input  logic [WIDTH-1:0] y_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      err_count,
    output logic [15:0]      vec_count
);

    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? LFSR_DEFAULT_SEED : SEED;

    state_t           state_q, state_d;
    logic [15:0]      rem_q, rem_d;
    logic [1:0]       drain_q, drain_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             sel_q, sel_d;
    logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [15:0]      err_q, err_d, vec_q, vec_d;
    logic [WIDTH-1:0] exp_q [LAT];
    logic [WIDTH-1:0] exp_d [LAT];
    logic [LAT-1:0]   vld_q, vld_d;

    logic             lfsr_load, lfsr_adv;
    logic [15:0]      lfsr_state, lfsr_nxt;
    logic [7:0]       ref_full;

    wire_ops_lfsr16 #(.SEED(SEED_EFF)) u_lfsr (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .load    (lfsr_load),
        .advance (lfsr_adv),
        .state_o (lfsr_state)
    );

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        drain_d   = drain_q;
        a_d       = '0;
        b_d       = '0;
        sel_d     = 1'b0;
        err_d     = err_q;
        vec_d     = vec_q;
        lfsr_load = 1'b0;
        lfsr_adv  = 1'b0;
        lfsr_nxt  = lfsr_step(lfsr_state);

        // Expected value follows the vector currently on a_o/b_o/sel_o.
        ref_full = wire_ops_ref(8'(a_q), 8'(b_q), sel_q);
        exp_d[0] = ref_full[WIDTH-1:0];
        vld_d[0] = (state_q == ST_RUN);
        for (int i = 1; i < LAT; i++) begin
            exp_d[i] = exp_q[i-1];
            vld_d[i] = vld_q[i-1];
        end

        if (vld_q[LAT-1] && (y_i != exp_q[LAT-1]) && (err_q != 16'hFFFF)) begin
            err_d = err_q + 16'd1;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    err_d = 16'h0000;
                    vec_d = 16'h0000;
                    if (num_vec != 16'h0000) begin
                        state_d   = ST_RUN;
                        rem_d     = num_vec;
                        lfsr_load = 1'b1;
                        a_d       = SEED_EFF[WIDTH-1:0];
                        b_d       = SEED_EFF[8 +: WIDTH];
                        sel_d     = SEED_EFF[15];
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                if (vec_q != 16'hFFFF) begin
                    vec_d = vec_q + 16'd1;
                end
                if (rem_q == 16'd1) begin
                    state_d = ST_DRAIN;
                    drain_d = 2'(LAT - 1);
                end else begin
                    rem_d    = rem_q - 16'd1;
                    lfsr_adv = 1'b1;
                    a_d      = lfsr_nxt[WIDTH-1:0];
                    b_d      = lfsr_nxt[8 +: WIDTH];
                    sel_d    = lfsr_nxt[15];
                end
            end
            ST_DRAIN: begin
                if (drain_q == 2'd0) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q - 2'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);
        pass_d = (state_d == ST_DONE) && (err_d == 16'h0000);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
            rem_q   <= 16'h0000;
            drain_q <= 2'd0;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 16'h0000;
            vec_q   <= 16'h0000;
            vld_q   <= '0;
            for (int i = 0; i < LAT; i++) begin
                exp_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            drain_q <= drain_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            vec_q   <= vec_d;
            vld_q   <= vld_d;
            for (int i = 0; i < LAT; i++) begin
                exp_q[i] <= exp_d[i];
            end
        end
    end

    assign a_o       = a_q;
    assign b_o       = b_q;
    assign sel_o     = sel_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign vec_count = vec_q;

endmodule

// File: tb/tb_wire_ops_tester.sv
// Randomized bench: an external registered DUT model feeds y_i, a sequence model predicts the tester.
// Inputs change 1ns after the rising edge; outputs are sampled at that point too.
module tb_wire_ops_tester;

    localparam int WIDTH = 8;
    localparam int LAT   = 1;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        start;
    logic [15:0] num_vec;
    logic [7:0]  a_o, b_o, y_i;
    logic        sel_o, busy, done, pass;
    logic [15:0] err_count, vec_count;

    int n_checks = 0;
    int n_errors = 0;
    int mode_r   = 0;
    int key_r    = 0;

    always #5 sys_clk = ~sys_clk;

    wire_ops_tester #(.WIDTH(WIDTH), .LAT(LAT), .SEED(16'hACE1)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .start     (start),
        .num_vec   (num_vec),
        .a_o       (a_o),
        .b_o       (b_o),
        .sel_o     (sel_o),
        .y_i       (y_i),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .vec_count (vec_count)
    );

    function automatic bit corrupts(input logic [7:0] a, input logic [7:0] b, input int key);
        return ((int'(a) + int'(b) + key) % 4) == 0;
    endfunction

    // Device under test: registered WireOps with optional fault injection.
    logic [7:0] y_calc;
    logic [7:0] y_pipe [LAT];
    always_comb begin
        y_calc = sel_o ? (a_o & b_o) : (a_o ^ b_o);
        if (mode_r == 1) y_calc = ~y_calc;
        else if (mode_r == 2 && corrupts(a_o, b_o, key_r)) y_calc = y_calc ^ 8'h5A;
    end
    always @(posedge sys_clk) begin
        y_pipe[0] <= y_calc;
        for (int i = 1; i < LAT; i++) y_pipe[i] <= y_pipe[i-1];
    end
    assign y_i = y_pipe[LAT-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic run(input int n, input int mode, input int restart_at, input int rst_at);
        logic [7:0]  ea [$];
        logic [7:0]  eb [$];
        logic        es [$];
        logic [15:0] s;
        int          exp_err;
        int          done_from;
        bit          aborted;
        logic [7:0]  ya;

        s = 16'hACE1;
        exp_err = 0;
        for (int k = 0; k < n; k++) begin
            ea.push_back(s[7:0]);
            eb.push_back(s[15:8]);
            es.push_back(s[15]);
            if (mode == 1) exp_err++;
            else if (mode == 2 && corrupts(s[7:0], s[15:8], key_r)) exp_err++;
            s = (s % 2 == 1) ? ((s >> 1) ^ 16'hB400) : (s >> 1);
        end
        if (exp_err > 65535) exp_err = 65535;

        mode_r    = mode;
        num_vec   = 16'(n);
        start     = 1'b1;
        tick();
        start     = 1'b0;
        num_vec   = 16'($urandom);
        done_from = (n == 0) ? 1 : n + LAT + 1;
        aborted   = 1'b0;

        for (int c = 1; c <= done_from + 1; c++) begin
            if (c == rst_at) begin
                sys_rst = 1'b1;
                #1;
                check("rst busy", busy, 0);
                check("rst done", done, 0);
                check("rst pass", pass, 0);
                check("rst err", err_count, 0);
                check("rst vec", vec_count, 0);
                check("rst a", a_o, 0);
                check("rst b", b_o, 0);
                check("rst sel", sel_o, 0);
                sys_rst = 1'b0;
                aborted = 1'b1;
                break;
            end
            check($sformatf("busy n%0d c%0d", n, c), busy, (n != 0 && c <= n + LAT));
            check($sformatf("done n%0d c%0d", n, c), done, (c >= done_from));
            if (c < done_from) check($sformatf("pass lo n%0d c%0d", n, c), pass, 0);
            ya = (c <= n) ? ea[c-1] : 8'h00;
            check($sformatf("a n%0d c%0d", n, c), a_o, ya);
            check($sformatf("b n%0d c%0d", n, c), b_o, (c <= n) ? eb[c-1] : 8'h00);
            check($sformatf("sel n%0d c%0d", n, c), sel_o, (c <= n) ? es[c-1] : 1'b0);
            if (c == restart_at) begin
                start   = 1'b1;
                num_vec = 16'd5;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;

        if (!aborted) begin
            check($sformatf("final err n%0d", n), err_count, exp_err);
            check($sformatf("final vec n%0d", n), vec_count, n);
            check($sformatf("final pass n%0d", n), pass, (exp_err == 0));
            check($sformatf("final done n%0d", n), done, 1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        sys_rst = 1'b1;
        start   = 1'b0;
        num_vec = 16'd0;
        key_r   = int'($urandom_range(0, 3));
        tick();
        tick();
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset pass", pass, 0);
        check("reset err", err_count, 0);
        check("reset vec", vec_count, 0);
        check("reset a", a_o, 0);
        sys_rst = 1'b0;
        tick();

        // First vector of the seed, checked against literal values as well.
        num_vec = 16'd1;
        start   = 1'b1;
        tick();
        start = 1'b0;
        check("first a", a_o, 8'hE1);
        check("first b", b_o, 8'hAC);
        check("first sel", sel_o, 1'b1);
        repeat (LAT + 2) tick();
        check("first err", err_count, 0);
        check("first pass", pass, 1);

        run(1, 0, 0, 0);
        run(100, 0, 0, 0);
        run(4, 1, 0, 0);
        run(0, 0, 0, 0);
        run(10, 0, 3, 0);
        run(20, 0, 0, 5);
        check("idle after rst busy", busy, 0);
        check("idle after rst done", done, 0);
        run(3, 0, 0, 0);
        for (int r = 0; r < 6; r++) begin
            key_r = int'($urandom_range(0, 3));
            run(int'($urandom_range(1, 40)), int'($urandom_range(0, 2)), 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
